alu_seq_unit: RTL and testbench

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_comb_core.sv | 28 ++
 rtl/alu_seq_unit.sv | 71 +++++++
 tb/tb_alu_seq_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU operation codes, width defaults and sequencer state type
package alu_pkg;
   localparam int DATA_W_DEF  = 32;
   localparam int SHAMT_W_DEF = 5;
   typedef enum logic [3:0] {
      OP_AND  = 4'b0000,
      OP_OR   = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_SLL  = 4'b0011,
      OP_SRA  = 4'b0100,
      OP_SRL  = 4'b0101,
      OP_SUB  = 4'b0110,
      OP_XOR  = 4'b0111,
      OP_SLT  = 4'b1000,
      OP_SLTU = 4'b1001,
      OP_SGE  = 4'b1010,
      OP_SGEU = 4'b1011
   } alu_op_e;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;
endpackage

// File: rtl/alu_comb_core.sv
// alu_comb_core: single-cycle logic, arithmetic and compare operations
module alu_comb_core
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  alu_op_e           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] y
);
   // non-shift result; shift and undefined codes yield zero, compares are zero-extended
   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_XOR:  y = a ^ b;
         OP_SLT:  y[0] = $signed(a) < $signed(b);
         OP_SLTU: y[0] = a < b;
         OP_SGE:  y[0] = $signed(a) >= $signed(b);
         OP_SGEU: y[0] = a >= b;
         default: y = '0;
      endcase
   end
endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked ALU with a bit-serial shifter and registered result
module alu_seq_unit
   import alu_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int SHAMT_W = SHAMT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        operation,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic              zero
);
   state_e              state, state_nx;
   alu_op_e             op_in, op_q;
   logic [SHAMT_W-1:0]  shamt, cnt;
   logic [DATA_W-1:0]   core_y, shifted;
   logic                accept, in_shift;

   assign op_in     = alu_op_e'(operation);
   assign shamt     = src_b[SHAMT_W-1:0];
   assign in_shift  = op_in inside {OP_SLL, OP_SRA, OP_SRL};
   assign in_ready  = state == IDLE && !reset;
   assign out_valid = state == DONE;
   assign accept    = in_valid && in_ready;
   // the result register doubles as the shift accumulator; its MSB is the original sign for SRA
   assign shifted   = op_q == OP_SLL ? {result[DATA_W-2:0], 1'b0}
                    : {op_q == OP_SRA && result[DATA_W-1], result[DATA_W-1:1]};

   alu_comb_core #(.DATA_W(DATA_W)) u_core (
      .op (op_in),
      .a  (src_a),
      .b  (src_b),
      .y  (core_y)
   );

   // state register
   always_ff @(posedge clk)
      state <= reset ? IDLE : state_nx;

   // next state: zero-length shifts skip SHIFT, DONE waits for the consumer
   always_comb
      state_nx = state == IDLE  ? (accept ? (in_shift && shamt != '0 ? SHIFT : DONE) : IDLE)
               : state == SHIFT ? (cnt == SHAMT_W'(1) ? DONE : SHIFT)
               : (out_ready ? IDLE : DONE);

   // datapath: capture on accept, shift one bit per SHIFT cycle, hold otherwise
   always_ff @(posedge clk) begin
      if (reset) begin
         result <= '0;
         zero   <= 1'b0;
         cnt    <= '0;
         op_q   <= OP_AND;
      end else if (accept) begin
         op_q   <= op_in;
         cnt    <= shamt;
         result <= in_shift ? src_a : core_y;
         zero   <= in_shift ? src_a == '0 : core_y == '0;
      end else if (state == SHIFT) begin
         result <= shifted;
         zero   <= shifted == '0;
         cnt    <= cnt - SHAMT_W'(1);
      end
   end
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed vector table plus handshake, backpressure and reset sequences
module tb_alu_seq_unit;
   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, out_valid, out_ready, zero;
   logic [3:0]  operation;
   logic [31:0] src_a, src_b, result;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        z;
      int          lat;
   } vec_t;

   vec_t vecs[19];

   alu_seq_unit dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .operation (operation),
      .src_a     (src_a),
      .src_b     (src_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic ez, input int elat);
      int w = 0;
      int lat = 1;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk({name, "_ready_before"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; operation = op; src_a = a; src_b = b;
      @(negedge clk);
      in_valid = 1'b0; operation = 4'($urandom); src_a = $urandom; src_b = $urandom;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk({name, "_latency"}, lat, elat);
      chk({name, "_result"}, result, er);
      chk({name, "_zero"}, {31'd0, zero}, {31'd0, ez});
      @(negedge clk);
      chk({name, "_ready_after"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      bit saw;
      vecs[0]  = '{4'b0010, 32'hFFFFFFFF, 32'h1,  32'h0,        1'b1, 1};
      vecs[1]  = '{4'b0100, 32'h80000000, 32'h4,  32'hF8000000, 1'b0, 5};
      vecs[2]  = '{4'b0011, 32'h00001234, 32'h20, 32'h00001234, 1'b0, 1};
      vecs[3]  = '{4'b0011, 32'h00000001, 32'd31, 32'h80000000, 1'b0, 32};
      vecs[4]  = '{4'b1000, 32'hFFFFFFFF, 32'h0,  32'h1,        1'b0, 1};
      vecs[5]  = '{4'b1001, 32'hFFFFFFFF, 32'h0,  32'h0,        1'b1, 1};
      vecs[6]  = '{4'b1011, 32'hFFFFFFFF, 32'h0,  32'h1,        1'b0, 1};
      vecs[7]  = '{4'b1010, 32'hFFFFFFFF, 32'h0,  32'h0,        1'b1, 1};
      vecs[8]  = '{4'b1111, 32'h5,        32'h3,  32'h0,        1'b1, 1};
      vecs[9]  = '{4'b0000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1};
      vecs[10] = '{4'b0001, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, 1};
      vecs[11] = '{4'b0111, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 1};
      vecs[12] = '{4'b0110, 32'h5,        32'h7,  32'hFFFFFFFE, 1'b0, 1};
      vecs[13] = '{4'b0101, 32'h80000000, 32'h4,  32'h08000000, 1'b0, 5};
      vecs[14] = '{4'b0100, 32'h70000000, 32'h4,  32'h07000000, 1'b0, 5};
      vecs[15] = '{4'b1100, 32'hFFFFFFFF, 32'h1,  32'h0,        1'b1, 1};
      vecs[16] = '{4'b1000, 32'h1,        32'h2,  32'h1,        1'b0, 1};
      vecs[17] = '{4'b1010, 32'h2,        32'h2,  32'h1,        1'b0, 1};
      vecs[18] = '{4'b0100, 32'hF0000000, 32'h24, 32'hFF000000, 1'b0, 5};

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      operation = 4'h0; src_a = '0; src_b = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_zero", {31'd0, zero}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_release_ready", {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < 19; i++)
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].z, vecs[i].lat);

      // SRA with the consumer stalled: in_ready stays low through accept+6
      out_ready = 1'b0;
      in_valid = 1'b1; operation = 4'b0100; src_a = 32'h80000000; src_b = 32'h4;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         in_valid = 1'b0; src_a = $urandom; src_b = $urandom;
         chk($sformatf("sra_ready_t%0d", k), {31'd0, in_ready}, 32'd0);
         chk($sformatf("sra_valid_t%0d", k), {31'd0, out_valid}, {31'd0, k >= 5});
         if (k == 5) chk("sra_result_t5", result, 32'hF8000000);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("sra_ready_t7", {31'd0, in_ready}, 32'd1);

      // SUB with 10 cycles of backpressure and stray requests
      out_ready = 1'b0;
      in_valid = 1'b1; operation = 4'b0110; src_a = 32'd5; src_b = 32'd7;
      @(negedge clk);
      chk("bp_valid_first", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; operation = 4'b0010; src_a = i; src_b = 32'd1;
         @(negedge clk);
         chk($sformatf("bp_result_%0d", i), result, 32'hFFFFFFFE);
         chk($sformatf("bp_valid_%0d", i), {31'd0, out_valid}, 32'd1);
         chk($sformatf("bp_ready_%0d", i), {31'd0, in_ready}, 32'd0);
         chk($sformatf("bp_zero_%0d", i), {31'd0, zero}, 32'd0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("bp_ready_after", {31'd0, in_ready}, 32'd1);
      chk("bp_valid_after", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      chk("bp_no_stray_op", {31'd0, out_valid}, 32'd0);

      // reset during SHIFT aborts the SRL silently
      in_valid = 1'b1; operation = 4'b0101; src_a = 32'h80000000; src_b = 32'd20;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_result", result, 32'd0);
      chk("mid_rst_zero", {31'd0, zero}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_ready_after", {31'd0, in_ready}, 32'd1);
      saw = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         saw |= out_valid;
      end
      chk("mid_rst_no_valid", {31'd0, saw}, 32'd0);
      run_op("post_rst_add", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
